// File: rtl/fxyz_sweep_ctrl.sv
// Exhaustive equivalence sweep of two N-input boolean implementations (s1 vs s2).
// Each vector is held SETTLE cycles, compared for one cycle, and mismatches are logged.
module fxyz_sweep_ctrl #(
    parameter int N      = 4,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              s1,
    input  logic              s2,
    output logic [N-1:0]      vec,
    output logic              busy,
    output logic              done,
    output logic [N:0]        mism_cnt,
    output logic [N-1:0]      first_mism,
    output logic              any_mism,
    output logic [2**N-1:0]   mism_map
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [N-1:0]  VEC_LAST    = '1;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        CHECK,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] settle_cnt;
    logic          clear_results;
    logic          record;
    logic          advance;
    logic          mismatch;

    assign mismatch = s1 ^ s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // CHECK records its compare even when abort leaves the sweep on the same edge.
    always_comb begin
        state_next    = state;
        clear_results = 1'b0;
        record        = 1'b0;
        advance       = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_next    = APPLY;
                    clear_results = 1'b1;
                end
            end
            APPLY: begin
                busy = 1'b1;
                if (abort) begin
                    state_next = IDLE;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                busy   = 1'b1;
                record = 1'b1;
                if (abort) begin
                    state_next = IDLE;
                end else if (vec == VEC_LAST) begin
                    state_next = DONE;
                end else begin
                    advance    = 1'b1;
                    state_next = APPLY;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            settle_cnt <= '0;
        end else if (state == APPLY && !abort && settle_cnt != SETTLE_LAST) begin
            settle_cnt <= settle_cnt + CW'(1);
        end else begin
            settle_cnt <= '0;
        end
    end

    // Results and vec persist after DONE/abort until the next accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            vec        <= '0;
            mism_cnt   <= '0;
            first_mism <= '0;
            any_mism   <= 1'b0;
            mism_map   <= '0;
        end else begin
            if (clear_results) begin
                vec        <= '0;
                mism_cnt   <= '0;
                first_mism <= '0;
                any_mism   <= 1'b0;
                mism_map   <= '0;
            end
            if (record && mismatch) begin
                mism_cnt      <= mism_cnt + (N+1)'(1);
                mism_map[vec] <= 1'b1;
                if (!any_mism) begin
                    first_mism <= vec;
                    any_mism   <= 1'b1;
                end
            end
            if (advance) begin
                vec <= vec + N'(1);
            end
        end
    end

endmodule

// File: tb/tb_fxyz_sweep_ctrl.sv
// Randomized self-checking bench for fxyz_sweep_ctrl; expected results come from
// mask arithmetic over which vector indices have been compared so far.
module tb_fxyz_sweep_ctrl;

    localparam int N      = 4;
    localparam int SETTLE = 1;
    localparam int NV     = 1 << N;
    localparam int HOLD   = SETTLE + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic          s1;
    logic          s2;
    logic [N-1:0]  vec;
    logic          busy;
    logic          done;
    logic [N:0]    mism_cnt;
    logic [N-1:0]  first_mism;
    logic          any_mism;
    logic [NV-1:0] mism_map;

    logic [NV-1:0] truth;
    logic [NV-1:0] fail_mask;
    int            total = 0;
    int            bad   = 0;

    fxyz_sweep_ctrl #(.N(N), .SETTLE(SETTLE)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .s1(s1), .s2(s2),
        .vec(vec), .busy(busy), .done(done), .mism_cnt(mism_cnt),
        .first_mism(first_mism), .any_mism(any_mism), .mism_map(mism_map)
    );

    always #5 clk = ~clk;

    // s2 differs from s1 exactly on the vectors flagged in fail_mask.
    always_comb begin
        s1 = truth[vec];
        s2 = truth[vec] ^ fail_mask[vec];
    end

    function automatic logic [NV-1:0] model_map(input logic [NV-1:0] m, input int nrec);
        logic [NV-1:0] r;
        for (int i = 0; i < NV; i++) r[i] = (i < nrec) ? m[i] : 1'b0;
        return r;
    endfunction

    function automatic logic [N:0] model_cnt(input logic [NV-1:0] m, input int nrec);
        int c = 0;
        for (int i = 0; i < nrec; i++) if (m[i]) c++;
        return (N+1)'(c);
    endfunction

    function automatic logic [N-1:0] model_first(input logic [NV-1:0] m, input int nrec);
        for (int i = 0; i < nrec; i++) if (m[i]) return N'(i);
        return '0;
    endfunction

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; truth = '0; fail_mask = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++; if (vec !== '0) begin bad++; $display("[TB] FAIL reset vec: got %0h expected 0", vec); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset busy: got %b expected 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset done: got %b expected 0", done); end
        total++; if (mism_cnt !== '0) begin bad++; $display("[TB] FAIL reset mism_cnt: got %0d expected 0", mism_cnt); end
        total++; if (mism_map !== 16'h0000) begin bad++; $display("[TB] FAIL reset mism_map: got %h expected 0000", mism_map); end
        total++; if (any_mism !== 1'b0 || first_mism !== '0) begin bad++; $display("[TB] FAIL reset first/any: got %0h/%b expected 0/0", first_mism, any_mism); end
    endtask

    task automatic test_sweep(input string name, input logic [NV-1:0] mask, input bit disturb);
        int            busy_cycles = 0;
        bit            seen_done   = 0;
        bit            gap         = 0;
        logic [N-1:0]  ev;
        truth     = NV'($urandom);
        fail_mask = mask;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int c = 0; c < 4 * NV * HOLD && !seen_done && !gap; c++) begin
            if (c > 0) @(negedge clk);
            if (busy) begin
                ev = N'(busy_cycles / HOLD);
                total++; if (vec !== ev) begin bad++; $display("[TB] FAIL %s vec@%0d: got %0h expected %0h", name, busy_cycles, vec, ev); end
                busy_cycles++;
                start = disturb && (busy_cycles == 7 || busy_cycles == 8);
            end else if (done) begin
                seen_done = 1;
            end else begin
                gap = 1;
            end
        end
        start = 1'b0;
        total++; if (!seen_done) begin bad++; $display("[TB] FAIL %s done_pulse: got 0 expected 1 (gap=%0d)", name, gap); end
        total++; if (busy_cycles != NV * HOLD) begin bad++; $display("[TB] FAIL %s busy_len: got %0d expected %0d", name, busy_cycles, NV * HOLD); end
        total++; if (mism_cnt !== model_cnt(mask, NV)) begin bad++; $display("[TB] FAIL %s mism_cnt: got %0d expected %0d", name, mism_cnt, model_cnt(mask, NV)); end
        total++; if (mism_map !== model_map(mask, NV)) begin bad++; $display("[TB] FAIL %s mism_map: got %h expected %h", name, mism_map, model_map(mask, NV)); end
        total++; if (first_mism !== model_first(mask, NV)) begin bad++; $display("[TB] FAIL %s first_mism: got %0d expected %0d", name, first_mism, model_first(mask, NV)); end
        total++; if (any_mism !== (mask != '0)) begin bad++; $display("[TB] FAIL %s any_mism: got %b expected %b", name, any_mism, (mask != '0)); end
        if (disturb) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL %s after_done: got done=%b busy=%b expected 0/0", name, done, busy); end
        total++; if (vec !== N'(NV - 1)) begin bad++; $display("[TB] FAIL %s vec_hold: got %0h expected %0h", name, vec, NV - 1); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL %s start_in_done: got busy=%b expected 0", name, busy); end
    endtask

    // Abort sampled on the d-th edge after the start edge.
    task automatic test_abort(input int d);
        logic [NV-1:0] mask;
        int            nrec;
        logic [N-1:0]  ev;
        truth     = NV'($urandom);
        mask      = NV'($urandom);
        fail_mask = mask;
        nrec      = d / HOLD;
        ev        = N'((d - 1) / HOLD);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (d - 1) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL abort%0d busy: got %b expected 0", d, busy); end
        total++; if (vec !== ev) begin bad++; $display("[TB] FAIL abort%0d vec: got %0h expected %0h", d, vec, ev); end
        total++; if (mism_map !== model_map(mask, nrec)) begin bad++; $display("[TB] FAIL abort%0d mism_map: got %h expected %h", d, mism_map, model_map(mask, nrec)); end
        total++; if (mism_cnt !== model_cnt(mask, nrec)) begin bad++; $display("[TB] FAIL abort%0d mism_cnt: got %0d expected %0d", d, mism_cnt, model_cnt(mask, nrec)); end
        total++; if (first_mism !== model_first(mask, nrec)) begin bad++; $display("[TB] FAIL abort%0d first_mism: got %0d expected %0d", d, first_mism, model_first(mask, nrec)); end
        for (int c = 0; c < 3; c++) begin
            total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL abort%0d done: got %b expected 0", d, done); end
            @(negedge clk);
        end
        // Abort beats start in IDLE: nothing moves, prior results stay.
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0 || vec !== ev) begin bad++; $display("[TB] FAIL abort%0d start_abort_idle: got busy=%b vec=%0h expected 0/%0h", d, busy, vec, ev); end
        total++; if (mism_map !== model_map(mask, nrec)) begin bad++; $display("[TB] FAIL abort%0d results_kept: got %h expected %h", d, mism_map, model_map(mask, nrec)); end
    endtask

    task automatic test_reset_mid();
        logic [NV-1:0] mask;
        int            c;
        truth     = NV'($urandom);
        mask      = NV'($urandom) | NV'(16'h0008);
        fail_mask = mask;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (c = 0; c < 4 * NV && !(busy && vec == N'(7)); c++) @(negedge clk);
        total++; if (vec !== N'(7)) begin bad++; $display("[TB] FAIL rstmid reach7: got %0h expected 7", vec); end
        total++; if (mism_cnt !== model_cnt(mask, 7) || any_mism !== 1'b1) begin bad++; $display("[TB] FAIL rstmid partial: got %0d/%b expected %0d/1", mism_cnt, any_mism, model_cnt(mask, 7)); end
        reset = 1'b1;
        @(negedge clk);
        total++; if (vec !== '0 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("[TB] FAIL rstmid ctrl: got vec=%0h busy=%b done=%b expected 0", vec, busy, done); end
        total++; if (mism_cnt !== '0 || mism_map !== '0 || first_mism !== '0 || any_mism !== 1'b0) begin bad++; $display("[TB] FAIL rstmid results: got cnt=%0d map=%h first=%0d any=%b expected 0", mism_cnt, mism_map, first_mism, any_mism); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_sweep("equiv", '0, 1'b0);
        test_sweep("two_fail", 16'h1020, 1'b0);
        test_sweep("all_fail", 16'hFFFF, 1'b0);
        test_sweep("back_to_back", NV'($urandom), 1'b1);
        test_abort(10);
        test_abort(int'($urandom_range(1, NV * HOLD - 1)));
        test_abort(int'($urandom_range(1, NV * HOLD - 1)));
        test_reset_mid();
        test_sweep("after_reset", NV'($urandom), 1'b0);
        for (int i = 0; i < 3; i++) test_sweep("random", NV'($urandom), i[0]);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
